bsg_muxi2_pipe_stage: RTL and testbench



---
 rtl/bsg_muxi2_pipe_pkg.sv | 19 +
 rtl/bsg_muxi2_pipe_if.sv | 26 ++
 rtl/bsg_muxi2_pipe_chk.sv | 19 +
 rtl/bsg_muxi2_pipe_skid.sv | 95 +++++++++
 rtl/bsg_muxi2_pipe_stage.sv | 55 +++++
 tb/tb_bsg_muxi2_pipe_stage.sv | 140 ++++++++++++++
 6 files changed

// File: rtl/bsg_muxi2_pipe_pkg.sv
// Shared definitions for the bsg_muxi2_pipe_stage slice.
// The buffer is a 2-entry FIFO, and its state is its occupancy.
package bsg_muxi2_pipe_pkg;

  localparam int unsigned buf_depth_lp     = 2;
  localparam int unsigned default_width_lp = 5;

  // Occupancy encoding: the numeric value equals the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  // Data word at the default width. Modules carry their own width_p,
  // and they size their words as logic [width_p-1:0].
  typedef logic [default_width_lp-1:0] word_t;

endpackage

// File: rtl/bsg_muxi2_pipe_if.sv
// Operand/result handshake bundle for bsg_muxi2_pipe_stage.
// The master side drives operands and yumi. The slave side is the stage.
interface bsg_muxi2_pipe_if #(
  parameter int unsigned width_p = 5
);

  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] i0_i;
  logic [width_p-1:0] i1_i;
  logic [width_p-1:0] sel_i;
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;

  modport master (
    output v_i, i0_i, i1_i, sel_i, yumi_i,
    input  ready_o, v_o, data_o
  );

  modport slave (
    input  v_i, i0_i, i1_i, sel_i, yumi_i,
    output ready_o, v_o, data_o
  );

endinterface

// File: rtl/bsg_muxi2_pipe_chk.sv
// Simulation checker for the stage output handshake.
// It reports a yumi_i that arrives while v_o is low. The buffer
// ignores such a yumi_i, so this checker only reports the event.
module bsg_muxi2_pipe_chk (
  input logic clk_i,
  input logic reset_n_i,
  input logic v_o,
  input logic yumi_i
);

  // Flag consumer handshake violations once reset is released.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_o))
        else $info("bsg_muxi2_pipe: yumi_i asserted while v_o = 0 (ignored)");
    end
  end

endmodule

// File: rtl/bsg_muxi2_pipe_skid.sv
// This module is a 2-entry buffer with a valid/ready input and a valid/yumi output.
// All outputs are registered. ready_o does not depend on yumi_i, so a FULL
// buffer does not accept a push in the same cycle that it is popped.
module bsg_muxi2_pipe_skid
  import bsg_muxi2_pipe_pkg::*;
#(
  parameter int unsigned width_p = 5
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  occ_state_e         state_r, state_s;
  logic [width_p-1:0] head_r, head_s;
  logic [width_p-1:0] tail_r, tail_s;
  logic               v_r, ready_r;
  logic               push_s, pop_s;

  // A yumi_i that arrives while the buffer holds nothing is dropped here.
  assign push_s = v_i & ready_r;
  assign pop_s  = yumi_i & v_r;

  // Next-state computation for the occupancy and the two entries.
  always_comb begin
    state_s = state_r;
    head_s  = head_r;
    tail_s  = tail_r;
    case (state_r)
      EMPTY: begin
        if (push_s) begin
          head_s  = data_i;
          state_s = ONE;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        if (push_s && pop_s) begin
          head_s  = data_i;
          state_s = ONE;
        end else if (push_s) begin
          tail_s  = data_i;
          state_s = FULL;
        end else if (pop_s) begin
          head_s  = {width_p{1'b0}};
          state_s = EMPTY;
        end else begin
          state_s = ONE;
        end
      end
      FULL: begin
        if (pop_s) begin
          head_s  = tail_r;
          tail_s  = {width_p{1'b0}};
          state_s = ONE;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        head_s  = {width_p{1'b0}};
        tail_s  = {width_p{1'b0}};
        state_s = EMPTY;
      end
    endcase
  end

  // State register. The handshake flags are registered from the next occupancy.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= EMPTY;
      head_r  <= {width_p{1'b0}};
      tail_r  <= {width_p{1'b0}};
      v_r     <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      head_r  <= head_s;
      tail_r  <= tail_s;
      v_r     <= (state_s != EMPTY);
      ready_r <= (state_s != FULL);
    end
  end

  assign ready_o = ready_r;
  assign v_o     = v_r;
  assign data_o  = head_r;

endmodule

// File: rtl/bsg_muxi2_pipe_stage.sv
// Registered, flow-controlled inverting 2:1 bitwise mux stage.
// The stage computes data[k] = ~(sel[k] ? i1[k] : i0[k]) on input transfer
// and buffers the result in a 2-entry skid buffer.
// Define BSG_MUXI2_PIPE_POLARITY_RESTORE_EN to store the true mux output
// without the inversion. Timing and handshake are the same in both builds.
module bsg_muxi2_pipe_stage
  import bsg_muxi2_pipe_pkg::*;
#(
  parameter int unsigned width_p  = 5,
  parameter int unsigned harden_p = 1
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  bsg_muxi2_pipe_if.slave       bus
);

  logic [width_p-1:0] mux_s;
  logic [width_p-1:0] result_s;

  // The mux is AND-OR per bit, so an X on an unselected input is masked
  // to 0 by the select term. Both branches below are functionally equal.
  // The hardened branch gives synthesis a stable name to constrain.
  if (harden_p != 0) begin : g_hard
    assign mux_s = (bus.sel_i & bus.i1_i) | (~bus.sel_i & bus.i0_i);
  end else begin : g_soft
    assign mux_s = (bus.sel_i & bus.i1_i) | (~bus.sel_i & bus.i0_i);
  end

`ifdef BSG_MUXI2_PIPE_POLARITY_RESTORE_EN
  assign result_s = mux_s;
`else
  assign result_s = ~mux_s;
`endif

  bsg_muxi2_pipe_skid #(
    .width_p (width_p)
  ) u_skid (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (bus.v_i),
    .ready_o   (bus.ready_o),
    .data_i    (result_s),
    .v_o       (bus.v_o),
    .data_o    (bus.data_o),
    .yumi_i    (bus.yumi_i)
  );

  bsg_muxi2_pipe_chk u_chk (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_o       (bus.v_o),
    .yumi_i    (bus.yumi_i)
  );

endmodule

// File: tb/tb_bsg_muxi2_pipe_stage.sv
// Self-checking bench for bsg_muxi2_pipe_stage.
// The reference model is a queue of expected results. Each result is computed
// bit by bit from the select rule.
module tb_bsg_muxi2_pipe_stage;

  localparam int W = 5;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W-1:0] q[$];

  bsg_muxi2_pipe_if #(.width_p(W)) bus ();

  bsg_muxi2_pipe_stage #(.width_p(W), .harden_p(1)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, b, s);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) begin
      r[k] = s[k] ? b[k] : a[k];
`ifndef BSG_MUXI2_PIPE_POLARITY_RESTORE_EN
      r[k] = ~r[k];
`endif
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".v_o"},     {{(W-1){1'b0}}, bus.v_o},     {{(W-1){1'b0}}, q.size() != 0});
    chk({tag, ".ready_o"}, {{(W-1){1'b0}}, bus.ready_o}, {{(W-1){1'b0}}, q.size() != 2});
    chk({tag, ".data_o"},  bus.data_o, (q.size() != 0) ? q[0] : {W{1'b0}});
  endtask

  // Check at negedge, drive, then step the model at posedge.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] a, b, s,
                       input logic y);
    logic push, pop;
    logic [W-1:0] d;
    chk_outputs(tag);
    bus.v_i = v; bus.i0_i = a; bus.i1_i = b; bus.sel_i = s; bus.yumi_i = y;
    push = v && (q.size() != 2);
    pop  = y && (q.size() != 0);
    d    = ref_result(a, b, s);
    @(posedge clk);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(d);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] xv;
    reset_n = 1'b0;
    bus.v_i = 1'b0; bus.i0_i = '0; bus.i1_i = '0; bus.sel_i = '0; bus.yumi_i = 1'b0;
    @(negedge clk);

    // Reset held for 3 cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      bus.v_i = 1'($urandom); bus.yumi_i = 1'($urandom);
      bus.i0_i = W'($urandom); bus.i1_i = W'($urandom); bus.sel_i = W'($urandom);
      @(posedge clk); @(negedge clk);
      chk_outputs("reset_hold");
    end
    bus.v_i = 1'b0; bus.yumi_i = 1'b0;
    reset_n = 1'b1;

    // Single transfer, then pop.
    cycle("single_push", 1'b1, 5'h0F, 5'h15, 5'h1C, 1'b0);
`ifdef BSG_MUXI2_PIPE_POLARITY_RESTORE_EN
    chk("single_const", bus.data_o, 5'h17);
`else
    chk("single_const", bus.data_o, 5'h08);
`endif
    cycle("single_pop", 1'b0, 5'h00, 5'h00, 5'h00, 1'b1);
    cycle("single_after", 1'b0, 5'h00, 5'h00, 5'h00, 1'b0);

    // Illegal yumi on empty buffer: state must be unchanged.
    cycle("illegal_yumi", 1'b0, 5'h00, 5'h00, 5'h00, 1'b1);
    cycle("illegal_after", 1'b0, 5'h00, 5'h00, 5'h00, 1'b0);

    // Backpressure: A, B fill the buffer, C is held, then drain in order.
    cycle("bp_a", 1'b1, 5'h00, 5'h00, 5'h00, 1'b0);
    cycle("bp_b", 1'b1, 5'h0A, 5'h15, 5'h0F, 1'b0);
    for (int i = 0; i < 3; i++) cycle("bp_c_held", 1'b1, 5'h13, 5'h04, 5'h11, 1'b0);
    cycle("bp_pop_a", 1'b1, 5'h13, 5'h04, 5'h11, 1'b1);
    cycle("bp_c_push", 1'b1, 5'h13, 5'h04, 5'h11, 1'b0);
    for (int i = 0; i < 3; i++) cycle("bp_drain", 1'b0, 5'h00, 5'h00, 5'h00, 1'b1);

    // Unselected inputs carry X, and the result must still be fully known.
    xv = 'x;
    cycle("x_sel1", 1'b1, xv, 5'h0B, 5'h1F, 1'b0);
    cycle("x_sel0", 1'b1, 5'h16, xv, 5'h00, 1'b1);
    cycle("x_drain", 1'b0, 5'h00, 5'h00, 5'h00, 1'b1);

    // Continuous push+pop at ONE with incrementing i0 and sel = 0.
    cycle("stream_prime", 1'b1, 5'h00, 5'h1F, 5'h00, 1'b0);
    for (int i = 1; i <= 20; i++) cycle("stream", 1'b1, W'(i), 5'h1F, 5'h00, 1'b1);
    cycle("stream_end", 1'b0, 5'h00, 5'h00, 5'h00, 1'b1);

    // Random legal traffic.
    for (int i = 0; i < 200; i++)
      cycle("random", 1'($urandom), W'($urandom), W'($urandom), W'($urandom),
            (q.size() != 0) && ($urandom_range(0, 2) != 0));

    // Asynchronous reset mid-cycle with data buffered.
    cycle("ar_fill0", 1'b1, 5'h03, 5'h1C, 5'h05, 1'b0);
    cycle("ar_fill1", 1'b1, 5'h11, 5'h0E, 5'h1A, 1'b0);
    bus.v_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    chk_outputs("async_reset");
    @(negedge clk);
    chk_outputs("async_reset_hold");
    reset_n = 1'b1;
    cycle("post_reset", 1'b1, 5'h1E, 5'h01, 5'h0C, 1'b0);
    cycle("post_reset_pop", 1'b0, 5'h00, 5'h00, 5'h00, 1'b1);
    chk_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
